// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_pkg
// Description : Shared definitions for the router link scheduler: port
//               indices, port count, FSM state encoding and the cyclic
//               port-index helper used by the round-robin search.
// Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

   // Number of router ports and width of a port index
   localparam int NUM_PORTS = 5;
   localparam int PORT_W    = 3;

   // Port indices; the bit order of every per-port vector is {L,N,E,S,W}
   localparam logic [PORT_W-1:0] L = 3'd4;
   localparam logic [PORT_W-1:0] N = 3'd3;
   localparam logic [PORT_W-1:0] E = 3'd2;
   localparam logic [PORT_W-1:0] S = 3'd1;
   localparam logic [PORT_W-1:0] W = 3'd0;

   // Scheduler FSM state encoding
   localparam int STATE_W = 2;
   localparam logic [STATE_W-1:0] ST_INIT = 2'd0;
   localparam logic [STATE_W-1:0] ST_ARB  = 2'd1;
   localparam logic [STATE_W-1:0] ST_XFER = 2'd2;
   localparam logic [STATE_W-1:0] ST_HOLD = 2'd3;

   // (base - step) modulo NUM_PORTS. Two conditional subtractions keep the
   // result in range even for out-of-range base values, so callers can
   // index a NUM_PORTS-wide vector safely.
   function automatic logic [PORT_W-1:0] port_sub(input logic [PORT_W-1:0] base,
                                                  input logic [PORT_W-1:0] step);
      logic [PORT_W:0] t;
      t = {1'b0, base} + (PORT_W+1)'(NUM_PORTS) - {1'b0, step};
      if (t >= (PORT_W+1)'(NUM_PORTS)) t = t - (PORT_W+1)'(NUM_PORTS);
      if (t >= (PORT_W+1)'(NUM_PORTS)) t = t - (PORT_W+1)'(NUM_PORTS);
      return t[PORT_W-1:0];
   endfunction

endpackage : router_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Finds the first set request
//               bit in the cyclic downward order ptr, ptr-1, ..., 0, 4, ...
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
   import router_pkg::*;
(
   input  logic [NUM_PORTS-1:0] request_i,
   input  logic [PORT_W-1:0]    ptr_i,
   output logic [PORT_W-1:0]    winner_o,
   output logic                 valid_o
);

   // Walk the search order from last to first so the earliest hit wins
   always_comb begin
      winner_o = '0;
      valid_o  = 1'b0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         if (request_i[port_sub(ptr_i, PORT_W'(k))]) begin
            winner_o = port_sub(ptr_i, PORT_W'(k));
            valid_o  = 1'b1;
         end
      end
   end

endmodule : rr_pick
`default_nettype wire

// File: rtl/link_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : link_scheduler
// Description : Output-link scheduler for a 5-port router. Arbitrates among
//               the input channels with rotating priority, forwards the
//               winning flit to the downstream buffer for one cycle, then
//               masks arbitration for a programmable number of cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module link_scheduler
   import router_pkg::*;
#(
   parameter int DATA_SIZE      = 8,
   parameter int MASK_CNT_INIT  = 1,
   parameter int MASK_CNT_DELAY = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_PORTS-1:0]           request,
   input  logic                           empty_i,
   input  logic [NUM_PORTS*DATA_SIZE-1:0] data_i,
   output logic [NUM_PORTS-1:0]           grant,
   output logic                           fill_o,
   output logic [DATA_SIZE-1:0]           data_o,
   output logic                           busy
);

   // Counter sized for the larger of the two mask lengths (at least 1 bit)
   localparam int CNT_MAX = (MASK_CNT_INIT > MASK_CNT_DELAY) ? MASK_CNT_INIT : MASK_CNT_DELAY;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

   localparam logic [CNT_W-1:0] CNT_INIT_V  = CNT_W'(MASK_CNT_INIT);
   localparam logic [CNT_W-1:0] CNT_DELAY_V = CNT_W'(MASK_CNT_DELAY);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   logic [STATE_W-1:0]   state_q, state_d;
   logic [CNT_W-1:0]     cnt_q,   cnt_d;
   logic [PORT_W-1:0]    ptr_q,   ptr_d;
   logic [NUM_PORTS-1:0] grant_q, grant_d;
   logic                 fill_q,  fill_d;
   logic [DATA_SIZE-1:0] data_q,  data_d;

   logic [PORT_W-1:0]    pick_winner;
   logic                 pick_valid;
   logic                 do_grant;
   logic [DATA_SIZE-1:0] flit [NUM_PORTS];

   // Unpack the concatenated input bus into per-port flits (index 4 = L = MSB)
   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_flit
      assign flit[gi] = data_i[gi*DATA_SIZE +: DATA_SIZE];
   end

   rr_pick u_rr_pick (
      .request_i (request),
      .ptr_i     (ptr_q),
      .winner_o  (pick_winner),
      .valid_o   (pick_valid)
   );

   // A grant is only possible in ARB with some request and room downstream
   assign do_grant = (state_q == ST_ARB) && pick_valid && empty_i;

   // State and datapath registers; reset aborts any grant in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_INIT;
         cnt_q   <= CNT_INIT_V;
         ptr_q   <= L;
         grant_q <= '0;
         fill_q  <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         fill_q  <= fill_d;
         data_q  <= data_d;
      end
   end

   // Next-state logic. HOLD hands over to ARB on the edge where the counter
   // would reach zero, so the ARB cycle itself is one of the dead cycles.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INIT: if (cnt_q == '0) state_d = ST_ARB;
         ST_ARB:  if (do_grant) state_d = ST_XFER;
         ST_XFER: state_d = (MASK_CNT_DELAY == 0) ? ST_ARB : ST_HOLD;
         ST_HOLD: if (cnt_q <= CNT_ONE) state_d = ST_ARB;
         default: state_d = ST_INIT;
      endcase
   end

   // Registered-output and counter/pointer next values
   always_comb begin
      grant_d = '0;
      fill_d  = 1'b0;
      data_d  = data_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_INIT: if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
         ST_ARB: begin
            if (do_grant) begin
               grant_d = {{(NUM_PORTS-1){1'b0}}, 1'b1} << pick_winner;
               fill_d  = 1'b1;
               data_d  = flit[pick_winner];
               ptr_d   = (pick_winner == W) ? L : (pick_winner - PORT_W'(1));
            end
         end
         ST_XFER: cnt_d = CNT_DELAY_V;
         ST_HOLD: if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = CNT_INIT_V;
      endcase
   end

   assign grant  = grant_q;
   assign fill_o = fill_q;
   assign data_o = data_q;
   assign busy   = (state_q != ST_ARB);

endmodule : link_scheduler
`default_nettype wire

// File: doc/link_scheduler.md
LINK_SCHEDULER -- requirements
Module: link_scheduler

Interface
REQ-001 Parameter DATA_SIZE, default 8, flit width in bits.
REQ-002 Parameter MASK_CNT_INIT, default 1, idle cycles after reset before the first arbitration.
REQ-003 Parameter MASK_CNT_DELAY, default 1, dead cycles between one grant and the next arbitration.
REQ-004 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port request  input  5  per-input-channel request; bit order {L,N,E,S,W} = bits 4..0.
REQ-007 Port empty_i  input  1  downstream buffer empty; 1 = the output may be written.
REQ-008 Port data_i  input  5*DATA_SIZE  channel flits concatenated {L,N,E,S,W}, MSB slice = L.
REQ-009 Port grant  output  5  one-hot grant to the winning channel, registered.
REQ-010 Port fill_o  output  1  write strobe to the downstream buffer, registered.
REQ-011 Port data_o  output  DATA_SIZE  winning flit, registered, valid while fill_o=1.
REQ-012 Port busy  output  1  1 in every state except ARB.

Function
REQ-013 The FSM SHALL have four states: INIT, ARB, XFER, HOLD.
REQ-014 INIT SHALL load cnt=MASK_CNT_INIT on reset, decrement once per cycle, and enter ARB in the cycle after cnt reaches 0; with MASK_CNT_INIT=0, ARB SHALL be entered one cycle after reset deasserts.
REQ-015 In ARB, a grant SHALL issue only when request!=0 and empty_i=1; otherwise the FSM SHALL stay in ARB with grant=0 and fill_o=0.
REQ-016 The winner SHALL be the first set request bit found by a cyclic downward search starting at index ptr: ptr, ptr-1, ... 0, 4, ....
REQ-017 On a grant, the next edge SHALL set grant to onehot(winner), fill_o=1 and data_o=data_i[winner slice], and SHALL move to XFER.
REQ-018 On the same edge, ptr SHALL update to (winner==0) ? 4 : winner-1 (rotating priority).
REQ-019 XFER SHALL last exactly one cycle.
REQ-020 The grant is committed: a request drop or an empty_i change during XFER SHALL NOT cancel it.
REQ-021 Leaving XFER, grant and fill_o SHALL clear, data_o SHALL hold, cnt SHALL load MASK_CNT_DELAY, and the FSM SHALL enter HOLD; with MASK_CNT_DELAY=0 it SHALL enter ARB directly.
REQ-022 HOLD SHALL decrement cnt each cycle and enter ARB after cnt reaches 0; no grant SHALL issue in HOLD.
REQ-023 Between consecutive grants there SHALL be exactly 1+MASK_CNT_DELAY cycles with fill_o=0, assuming continuous demand.
REQ-024 grant SHALL be one-hot or zero in every cycle, and fill_o SHALL equal |grant.
REQ-025 cnt SHALL be wide enough to hold the larger of MASK_CNT_INIT and MASK_CNT_DELAY.
REQ-026 cnt SHALL never underflow.

Reset
REQ-027 While rst=1 at a clock edge, the block SHALL set: state=INIT, grant=0, fill_o=0, data_o=0, ptr=4, cnt=MASK_CNT_INIT, busy=1.
REQ-028 A reset asserted during XFER or HOLD SHALL abort the sequence, and grant and fill_o SHALL be 0 from the next cycle.
REQ-029 No grant issued before the reset SHALL be replayed afterwards.

Structure
REQ-030 A shared package router_pkg SHALL hold:
- port index constants L=4, N=3, E=2, S=1, W=0;
- NUM_PORTS=5;
- the FSM state encoding.
REQ-031 The cyclic search SHALL be a combinational sub-module rr_pick (inputs request and ptr; outputs winner index and valid).
REQ-032 link_scheduler SHALL instantiate rr_pick and hold all registers.

Verification
REQ-033 Reset scenario: MASK_CNT_INIT=3, request=5'b11111, empty_i=1 from reset -> first fill_o on the 5th edge after rst deasserts; grant=5'b10000, data_o = L slice.
REQ-034 Rotation scenario: MASK_CNT_DELAY=1, all requests held high, empty_i=1 -> grants L,N,E,S,W,L..., one every 3 cycles.
REQ-035 Back-pressure scenario: request=5'b00100 with empty_i=0 for 10 cycles -> grant=0 throughout; empty_i rising -> grant=5'b00100 one cycle later.
REQ-036 Committed-grant scenario: request drops to 0 in the XFER cycle -> fill_o still pulses exactly one cycle, then HOLD, then ARB with no grant.
REQ-037 Reset-abort scenario: rst asserted in the XFER cycle -> grant=0 and fill_o=0 next cycle, state=INIT, ptr=4.
REQ-038 Zero-delay scenario: MASK_CNT_DELAY=0, request=5'b00011 -> grants S,W,S,W alternating every 2 cycles.
